// File: rtl/gerenciador_memoria_grafo.sv
// Graph memory responder: relations RAM plus obstacle bitmap, 1-cycle reads, host loads, clear sweep.
// Optional saturating read counter enabled by defining GMA_CONTADOR_LEITURAS_EN.
module gerenciador_memoria_grafo #(
  parameter int unsigned ADDR_WIDTH          = 8,
  parameter int unsigned RELACOES_DATA_WIDTH = 8
`ifdef GMA_CONTADOR_LEITURAS_EN
  , parameter int unsigned LEITURAS_WIDTH    = 16
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_limpar_in,
  input  logic                           cfg_relacoes_wr_en_in,
  input  logic [ADDR_WIDTH-1:0]          cfg_relacoes_wr_addr_in,
  input  logic [RELACOES_DATA_WIDTH-1:0] cfg_relacoes_wr_data_in,
  input  logic                           cfg_obstaculos_wr_en_in,
  input  logic [ADDR_WIDTH-1:0]          cfg_obstaculos_wr_addr_in,
  input  logic                           cfg_obstaculos_wr_data_in,
  output logic                           gma_pronto_out,
  input  logic                           lvv_relacoes_rd_enable_in,
  input  logic [ADDR_WIDTH-1:0]          lvv_relacoes_rd_addr_in,
  output logic [RELACOES_DATA_WIDTH-1:0] gma_relacoes_rd_data_out,
  output logic                           gma_relacoes_rd_valid_out,
  input  logic                           lvv_obstaculos_rd_enable_in,
  input  logic [ADDR_WIDTH-1:0]          lvv_obstaculos_rd_addr_in,
  output logic                           gma_obstaculos_rd_data_out,
  output logic                           gma_obstaculos_rd_valid_out
`ifdef GMA_CONTADOR_LEITURAS_EN
  , output logic [LEITURAS_WIDTH-1:0]    gma_leituras_out
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ULTIMO_ENDERECO = '1;

  typedef enum logic {OCIOSO, LIMPANDO} estado_t;

  estado_t                        estado, estado_prox;
  logic [ADDR_WIDTH-1:0]          contador;
  logic                           rel_we_c, obs_we_c;
  logic [ADDR_WIDTH-1:0]          rel_waddr_c, obs_waddr_c;
  logic [RELACOES_DATA_WIDTH-1:0] rel_wdata_c;
  logic                           obs_wdata_c;

  logic [RELACOES_DATA_WIDTH-1:0] mem_relacoes [DEPTH];
  logic [DEPTH-1:0]               mem_obstaculos;

  // State register; pronto follows the next state so it equals (state == OCIOSO)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado         <= LIMPANDO;
      gma_pronto_out <= 1'b0;
    end else begin
      estado         <= estado_prox;
      gma_pronto_out <= (estado_prox == OCIOSO);
    end
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:   if (cfg_limpar_in) estado_prox = LIMPANDO;
      LIMPANDO: if (!cfg_limpar_in && contador == ULTIMO_ENDERECO) estado_prox = OCIOSO;
      default:  estado_prox = LIMPANDO;
    endcase
  end

  // Write port mux: the sweep owns both memories while clearing, host otherwise
  always_comb begin
    rel_we_c    = 1'b0;
    rel_waddr_c = cfg_relacoes_wr_addr_in;
    rel_wdata_c = cfg_relacoes_wr_data_in;
    obs_we_c    = 1'b0;
    obs_waddr_c = cfg_obstaculos_wr_addr_in;
    obs_wdata_c = cfg_obstaculos_wr_data_in;
    if (estado == LIMPANDO) begin
      rel_we_c    = 1'b1;
      rel_waddr_c = contador;
      rel_wdata_c = '0;
      obs_we_c    = 1'b1;
      obs_waddr_c = contador;
      obs_wdata_c = 1'b0;
    end else begin
      rel_we_c = cfg_relacoes_wr_en_in;
      obs_we_c = cfg_obstaculos_wr_en_in;
    end
  end

  // Sweep address; wraps to zero naturally after the last address
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     contador <= '0;
    else if (cfg_limpar_in)      contador <= '0;
    else if (estado == LIMPANDO) contador <= contador + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rel_we_c) mem_relacoes[rel_waddr_c] <= rel_wdata_c;
  end

  always_ff @(posedge clk) begin
    if (obs_we_c) mem_obstaculos[obs_waddr_c] <= obs_wdata_c;
  end

  // Read-first ports; during the sweep nodes read as blocked with no neighbours
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gma_relacoes_rd_valid_out   <= 1'b0;
      gma_relacoes_rd_data_out    <= '0;
      gma_obstaculos_rd_valid_out <= 1'b0;
      gma_obstaculos_rd_data_out  <= 1'b1;
    end else begin
      gma_relacoes_rd_valid_out   <= lvv_relacoes_rd_enable_in;
      gma_obstaculos_rd_valid_out <= lvv_obstaculos_rd_enable_in;
      if (lvv_relacoes_rd_enable_in)
        gma_relacoes_rd_data_out <= (estado == LIMPANDO) ? '0 : mem_relacoes[lvv_relacoes_rd_addr_in];
      if (lvv_obstaculos_rd_enable_in)
        gma_obstaculos_rd_data_out <= (estado == LIMPANDO) ? 1'b1 : mem_obstaculos[lvv_obstaculos_rd_addr_in];
    end
  end

`ifdef GMA_CONTADOR_LEITURAS_EN
  localparam int unsigned SOMA_WIDTH = LEITURAS_WIDTH + 1;

  logic [1:0]            incremento_c;
  logic [SOMA_WIDTH-1:0] soma_c;

  always_comb begin
    incremento_c = 2'(lvv_relacoes_rd_enable_in) + 2'(lvv_obstaculos_rd_enable_in);
    soma_c       = {1'b0, gma_leituras_out} + SOMA_WIDTH'(incremento_c);
  end

  // Saturating count of accepted read requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         gma_leituras_out <= '0;
    else if (cfg_limpar_in)          gma_leituras_out <= '0;
    else if (soma_c[LEITURAS_WIDTH]) gma_leituras_out <= '1;
    else                             gma_leituras_out <= soma_c[LEITURAS_WIDTH-1:0];
  end
`endif

endmodule
